// File: rtl/mux_share_pkg.sv
// Shared types and sizing helpers for the shared-mux arbiter.
package mux_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN0  = 2'b01,
    OWN1  = 2'b10,
    GUARD = 2'b11
  } state_t;

  localparam int DEF_MAX_HOLD     = 8;
  localparam int DEF_GUARD_CYCLES = 1;

  // One counter width serves both the hold and the guard counters.
  function automatic int cnt_width(input int max_hold, input int guard_cycles);
    int m;
    m = (max_hold > guard_cycles) ? max_hold : guard_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mux_share_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the side that did not own last wins.
module rr_pick2
  import mux_share_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_idx,
  output logic any
);

  // Pure combinational pick, shared by the IDLE and GUARD-exit paths.
  always_comb begin
    any       = req0 | req1;
    grant_idx = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/mux_share_arbiter.sv
// Shares one 2:1 mux between two requesters. The select only moves on the
// edge that issues a new grant, and every hand-over is padded with guard
// cycles during which the registered output is held at zero.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | no owner, z = 0, waiting for a request
//   OWN0  | requester 0 owns the mux, z follows in0
//   OWN1  | requester 1 owns the mux, z follows in1
//   GUARD | post-release quiet time, no grant, z = 0, sel held
module mux_share_arbiter
  import mux_share_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter int MAX_HOLD     = DEF_MAX_HOLD,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] z,
  output logic              busy
);

  localparam int             CNT_W      = cnt_width(MAX_HOLD, GUARD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  state_t             state, state_nxt;
  logic               last, last_nxt;
  logic               sel_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [CNT_W-1:0]   guard_cnt, guard_nxt;
  logic [DATA_W-1:0]  z_nxt;
  logic               pick_idx, pick_any;
  logic               forced0, forced1;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // A tenure is cut short only when the other side is actually waiting.
  assign forced0 = (hold_cnt == HOLD_LAST) && req1;
  assign forced1 = (hold_cnt == HOLD_LAST) && req0;

  // Next-state, counter and round-robin pointer logic.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
    hold_nxt  = hold_cnt;
    guard_nxt = guard_cnt;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = pick_idx ? OWN1 : OWN0;
          sel_nxt   = pick_idx;
          hold_nxt  = '0;
        end
      end
      OWN0: begin
        if (!req0 || forced0) begin
          state_nxt = GUARD;
          last_nxt  = 1'b0;
          guard_nxt = GUARD_LOAD;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      OWN1: begin
        if (!req1 || forced1) begin
          state_nxt = GUARD;
          last_nxt  = 1'b1;
          guard_nxt = GUARD_LOAD;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      GUARD: begin
        if (guard_cnt == '0) begin
          if (pick_any) begin
            state_nxt = pick_idx ? OWN1 : OWN0;
            sel_nxt   = pick_idx;
            hold_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          guard_nxt = guard_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data for the next cycle: only the owner's input ever reaches z.
  always_comb begin
    z_nxt = '0;
    if (state_nxt == OWN0) z_nxt = in0;
    else if (state_nxt == OWN1) z_nxt = in1;
  end

  // State, counters and registered outputs; reset drops any grant at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      hold_cnt  <= '0;
      guard_cnt <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      z         <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      sel       <= sel_nxt;
      hold_cnt  <= hold_nxt;
      guard_cnt <= guard_nxt;
      gnt0      <= (state_nxt == OWN0);
      gnt1      <= (state_nxt == OWN1);
      busy      <= (state_nxt != IDLE);
      z         <= z_nxt;
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: two instances (short/long guard) share one
// stimulus stream and are compared against an ownership-level model.
module tb_mux_share_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, req1;
  logic [3:0] in0, in1;

  logic       gnt0_a, gnt1_a, sel_a, busy_a;
  logic [3:0] z_a;
  logic       gnt0_b, gnt1_b, sel_b, busy_b;
  logic [3:0] z_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_share_arbiter #(.DATA_W(4), .MAX_HOLD(8), .GUARD_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .z(z_a), .busy(busy_a)
  );

  mux_share_arbiter #(.DATA_W(4), .MAX_HOLD(5), .GUARD_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .z(z_b), .busy(busy_b)
  );

  // owner: -1 none, else index; tenure: cycles owned so far;
  // guard_left: quiet cycles still to show (0 when not guarding).
  typedef struct {
    int         owner;
    int         tenure;
    int         guard_left;
    int         last;
    logic       sel;
    logic [3:0] z;
  } mdl_t;

  mdl_t ma, mb;
  logic prev_sel_a, prev_sel_b;
  logic [1:0] prev_gnt_a, prev_gnt_b;

  function automatic mdl_t mreset();
    mdl_t n;
    n.owner = -1; n.tenure = 0; n.guard_left = 0; n.last = 1; n.sel = 1'b0; n.z = 4'h0;
    return n;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic r0, input logic r1,
                                 input logic [3:0] d0, input logic [3:0] d1,
                                 input int max_hold, input int guard_cycles);
    mdl_t n;
    logic mine, other;
    n = m;
    if (m.owner >= 0) begin
      mine  = (m.owner == 0) ? r0 : r1;
      other = (m.owner == 0) ? r1 : r0;
      if (!mine || (other && m.tenure >= max_hold)) begin
        n.last = m.owner;
        n.owner = -1;
        n.guard_left = guard_cycles;
      end else begin
        n.tenure = m.tenure + 1;
      end
    end else if (m.guard_left > 1) begin
      n.guard_left = m.guard_left - 1;
    end else begin
      n.guard_left = 0;
      if (r0 || r1) begin
        n.owner  = (r0 && r1) ? (1 - m.last) : (r1 ? 1 : 0);
        n.tenure = 1;
        n.sel    = (n.owner == 1);
      end
    end
    n.z = (n.owner == 0) ? d0 : (n.owner == 1) ? d1 : 4'h0;
    return n;
  endfunction

  function automatic logic [7:0] mexp(input mdl_t m);
    logic g0, g1, b;
    g0 = (m.owner == 0);
    g1 = (m.owner == 1);
    b  = (m.owner >= 0) || (m.guard_left > 0);
    return {g0, g1, m.sel, b, m.z};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset_n) begin
      ma = mreset();
      mb = mreset();
    end else begin
      ma = mstep(ma, req0, req1, in0, in1, 8, 1);
      mb = mstep(mb, req0, req1, in0, in1, 5, 3);
    end
    @(negedge clk);
    check({tag, "_a"}, {gnt0_a, gnt1_a, sel_a, busy_a, z_a}, mexp(ma));
    check({tag, "_b"}, {gnt0_b, gnt1_b, sel_b, busy_b, z_b}, mexp(mb));
    if (reset_n && sel_a !== prev_sel_a) check("sel_inv_a", {6'b0, prev_gnt_a}, 8'h00);
    if (reset_n && sel_b !== prev_sel_b) check("sel_inv_b", {6'b0, prev_gnt_b}, 8'h00);
    prev_sel_a = sel_a; prev_gnt_a = {gnt0_a, gnt1_a};
    prev_sel_b = sel_b; prev_gnt_b = {gnt0_b, gnt1_b};
  endtask

  task automatic rand_data();
    in0 = 4'($urandom_range(0, 15));
    in1 = 4'($urandom_range(0, 15));
  endtask

  initial begin
    reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    in0 = 4'h1; in1 = 4'h1;
    ma = mreset(); mb = mreset();
    prev_sel_a = 1'b0; prev_sel_b = 1'b0;
    prev_gnt_a = 2'b00; prev_gnt_b = 2'b00;

    // Reset held with both requesting.
    for (int i = 0; i < 3; i++) tick("reset");
    check("reset_zero_a", {gnt0_a, gnt1_a, sel_a, busy_a, z_a}, 8'h00);

    // Release: tie goes to requester 0, then contention alternates.
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin rand_data(); tick("contend"); end

    // Idle, then requester 1 alone for 20+ cycles, then drop.
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 6; i++) tick("idle");
    req1 = 1'b1; in1 = 4'hF;
    for (int i = 0; i < 22; i++) tick("single1");
    req1 = 1'b0;
    for (int i = 0; i < 6; i++) tick("drop1");

    // Voluntary release with the other side waiting.
    req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_data(); tick("own0"); end
    req0 = 1'b0; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin rand_data(); tick("volrel"); end

    // Same requester re-requests after its own release.
    req1 = 1'b0;
    tick("rerel");
    req1 = 1'b1;
    for (int i = 0; i < 6; i++) tick("rereq");

    // Randomised request patterns.
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) req0 = ~req0;
      if ($urandom_range(0, 5) == 0) req1 = ~req1;
      rand_data();
      tick("rand");
    end

    // Async reset between edges while requester 1 owns.
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 8; i++) tick("pre_ar");
    req1 = 1'b1; in1 = 4'hA;
    for (int i = 0; i < 3; i++) tick("own1");
    @(posedge clk);
    ma = mstep(ma, req0, req1, in0, in1, 8, 1);
    mb = mstep(mb, req0, req1, in0, in1, 5, 3);
    #2;
    reset_n = 1'b0;
    #1;
    ma = mreset(); mb = mreset();
    check("async_rst_a", {gnt0_a, gnt1_a, sel_a, busy_a, z_a}, mexp(ma));
    check("async_rst_b", {gnt0_b, gnt1_b, sel_b, busy_b, z_b}, mexp(mb));
    prev_sel_a = 1'b0; prev_sel_b = 1'b0;
    prev_gnt_a = 2'b00; prev_gnt_b = 2'b00;
    @(negedge clk);
    tick("in_rst");
    req1 = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("post_rst");
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_data(); tick("after_rst"); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Shares one 2:1 data multiplexer between two requesters, each with a request/grant handshake.
- Sequences the mux select so it never changes while a grant is active.
- Inserts guard cycles with the output forced low on every hand-over, so the registered output `z` never carries select-transition glitches.
- Sits in front of the gate-level mux path: it owns `sel` and registers the selected data.

Parameters:
- DATA_W, 1: width of in0, in1, z.
- MAX_HOLD, 8: max consecutive owned cycles while the other side is requesting (>=2).
- GUARD_CYCLES, 1: idle cycles between release and next grant (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 wants the mux.
- req1  input  1  requester 1 wants the mux.
- in0  input  DATA_W  requester 0 data.
- in1  input  DATA_W  requester 1 data.
- gnt0  output  1  requester 0 owns the mux.
- gnt1  output  1  requester 1 owns the mux.
- sel  output  1  mux select (0 = in0, 1 = in1).
- z  output  DATA_W  registered mux output.
- busy  output  1  high in OWN0, OWN1 or GUARD.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = IDLE; gnt0, gnt1, z, busy all 0.
  - sel = 0; round-robin pointer `last` = 1, so req0 wins the first tie.
  - hold counter and guard counter = 0.
- Reset mid-operation aborts any grant immediately, with no guard cycle.
- All outputs are registered. gnt0/gnt1 are one-hot or both 0, never both 1.
- States: IDLE, OWN0, OWN1, GUARD.
- IDLE:
  - Only req0 -> OWN0 and sel=0. Only req1 -> OWN1 and sel=1.
  - Both -> grant the side != last.
  - Neither -> stay in IDLE.
  - sel is loaded on the same edge as the grant, so sel and gntX change together.
- Latency: req sampled high in IDLE at edge N -> gntX=1 after edge N.
- OWNx, data path: z <= inX each cycle, so z lags inX by one cycle.
- OWNx, hold counter:
  - hold_cnt increments each OWN cycle.
  - It saturates at MAX_HOLD-1 if the other side is not requesting.
  - It clears on entry to OWN.
- OWNx exits to GUARD when either holds:
  - reqX = 0 (voluntary release), or
  - hold_cnt == MAX_HOLD-1 and the other req = 1 (forced release).
- On OWNx exit: gntX <= 0, last <= X, z <= 0, guard counter loaded with GUARD_CYCLES-1.
- The requester must not assume ownership in the cycle after gntX drops.
- If reqX stays high with the other side idle, ownership continues indefinitely.
- GUARD:
  - gnt0 = gnt1 = 0; z = 0; sel holds its previous value.
  - Counts down; at 0, apply the IDLE arbitration rules in the same cycle (GUARD -> OWNx directly, or -> IDLE if no req).
  - The new sel is loaded with the grant, so a sel change is always preceded by >= GUARD_CYCLES cycles of z=0 with no grant.
- IDLE: z = 0; busy = 0.
- Simultaneous release and request:
  - reqX drops while the other req rises in the same cycle -> GUARD, then grant the other.
  - Same requester re-requests after its own release while the other side is idle -> granted again after the guard.
- Requests dropping during GUARD: only requests sampled at the final guard cycle count.
- sel never toggles while gnt0 or gnt1 is 1; this is an invariant for the bench to assert.

Decomposition:
- Package mux_share_pkg:
  - state encoding constants: IDLE=2'b00, OWN0=2'b01, OWN1=2'b10, GUARD=2'b11;
  - default MAX_HOLD and GUARD_CYCLES;
  - counter width = clog2(max(MAX_HOLD, GUARD_CYCLES)).
- One sub-module, rr_pick2: a combinational two-way round-robin pick (req0, req1, last -> grant_idx, any).
  - It is reused in the IDLE and GUARD-exit paths.
- The FSM, counters and output registers stay in the top level.

Test Plan:
- Reset with req0=req1=1 and reset_n low for 3 cycles -> gnt0=gnt1=0, z=0, sel=0. Release reset -> gnt0=1 one cycle later; z follows in0 with one-cycle lag.
- Single requester, req1 only, in1=1 for 20 cycles, MAX_HOLD=8 -> gnt1 stays 1 for all 20 cycles and z=1 throughout. Drop req1 -> one guard cycle with z=0, then IDLE.
- Contention: req0 and req1 held high -> ownership alternates 0,1,0,... Each tenure is 8 cycles, separated by exactly GUARD_CYCLES cycles of gnt0=gnt1=0 and z=0.
- Voluntary release: req0 owned, req0 drops at cycle 3 with req1=1 -> gnt0=0 next edge, one guard cycle, then gnt1=1 and sel=1 on the same edge.
- GUARD_CYCLES=3 with in0=in1=1 and alternating ownership -> z shows exactly 3 zero cycles per hand-over. Assertion: sel changes only when gnt0=gnt1=0.
- Async reset asserted mid-OWN1, between clock edges -> gnt1, z and busy drop immediately without waiting for clk; state=IDLE on release.
